serial_subtractor: RTL and testbench



---
 rtl/arith_pkg.sv | 10 +
 rtl/full_subtractor.sv | 11 +
 rtl/serial_subtractor.sv | 94 +++++++++
 tb/tb_serial_subtractor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic types: serial subtractor state encoding and default width.
package arith_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;
endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell and a registered borrow.
// Handshake: start is taken on any edge where the FSM is not in RUN; done pulses one cycle with diff/bout valid.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       dbg_state
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_bout;

  logic             w_d;
  logic             w_br_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br_next)
  );

  assign w_accept   = start && (r_state != RUN);
  assign w_last     = (r_cnt == LAST);
  // New bit enters at the MSB; after WIDTH shifts the LSB-first stream is in order.
  assign w_res_next = {w_d, r_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_br    <= bin;
      r_cnt   <= '0;
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          r_res <= w_res_next[WIDTH-1:1];
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          if (w_last) begin
            r_diff  <= w_res_next;
            r_bout  <= w_br_next;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        IDLE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with an expected-result queue.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic [1:0]   dbg_state;

  logic [W:0]   exp_q[$];
  int           checks   = 0;
  int           errors   = 0;
  int           done_cnt = 0;
  logic         prev_done = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic binv);
    return {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv};
  endfunction

  // scoreboard: every done pops one expected {bout, diff}
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_width", {31'd0, prev_done}, 32'd0);
      check("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("result", {23'd0, bout, diff}, {23'd0, exp_q.pop_front()});
    end
    prev_done = done;
  end

  // driver: one operation, optional disturbance of start/operands during RUN
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv,
                        input logic [W:0] expv, input bit disturb);
    int i;
    @(negedge clk);
    a = av; b = bv; bin = binv; start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    for (i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (disturb && i <= 6) begin
        start = 1'($urandom_range(0, 1));
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        bin = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", i, 32'd8);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int waited;
    logic [W-1:0] na, nb;
    logic nbin;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // scenario 1
    run_op(8'h5A, 8'h3C, 1'b0, {1'b0, 8'h1E}, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_diff", {24'd0, diff}, 32'h1E);
    check("hold_bout", {31'd0, bout}, 32'd0);

    // scenario 2
    run_op(8'h00, 8'h01, 1'b0, {1'b1, 8'hFF}, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF}, 1'b0);

    // scenario 3
    run_op(8'h80, 8'h7F, 1'b1, {1'b0, 8'h00}, 1'b0);

    // scenario 4
    run_op(8'hC3, 8'h5E, 1'b1, {1'b0, 8'h64}, 1'b1);
    repeat (12) @(negedge clk);
    check("no_extra_done", exp_q.size(), 32'd0);

    // scenario 5: start held high, new operands presented in each DONE cycle
    @(negedge clk);
    a = 8'h9D; b = 8'h47; bin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h9D, 8'h47, 1'b0));
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!done && waited < 30);
      check("b2b_period", waited, 32'd9);
      if (k < 3) begin
        na = W'($urandom_range(1, 255));
        nb = W'($urandom_range(0, 255));
        nbin = 1'($urandom_range(0, 1));
        if (k == 2) begin na = 8'h12; nb = 8'h34; nbin = 1'b0; end
        a = na; b = nb; bin = nbin;
        exp_q.push_back(model(na, nb, nbin));
      end else begin
        start = 1'b0;
      end
    end
    check("b2b_last_diff", {24'd0, diff}, 32'hDE);
    check("b2b_last_bout", {31'd0, bout}, 32'd1);

    // scenario 6: asynchronous reset after the 4th RUN edge
    @(negedge clk);
    a = 8'hA5; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_diff", {24'd0, diff}, 32'd0);
    check("arst_bout", {31'd0, bout}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_no_done", done_cnt, 32'd9);
    run_op(8'h5A, 8'h3C, 1'b0, {1'b0, 8'h1E}, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    check("done_total", done_cnt, 32'd10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
